serial_adder: RTL and testbench

Bit-serial unsigned adder that accepts two WIDTH-bit operands over a valid/ready handshake. It computes the sum LSB-first, one bit per clock, using a single full-adder cell and a carry flip-flop, and returns {carry, sum} over a second valid/ready handshake. It is the device side of the operand-driver/result-checker protocol used by our arithmetic benches. With WIDTH=1 it is a registered half adder.

---
 rtl/serial_adder.sv | 56 +++++
 tb/tb_serial_adder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, with valid/ready handshakes on both sides
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0] cnt;
  logic c, s, cn;
  assign s = ra[0] ^ rb[0] ^ c;
  assign cn = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // operands shift right so the bit under the adder is always bit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ra    <= a;
      rb    <= b;
      c     <= 1'b0;
      cnt   <= '0;
      state <= CALC;
    end else if (state == CALC) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      c   <= cn;
      cnt <= cnt + CW'(1);
      sum <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
      if (cnt == CW'(WIDTH - 1)) begin
        carry <= cn;
        state <= DONE;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, carry;
  logic [7:0] a = '0, b = '0, sum;
  logic in_valid1 = 1'b0, out_ready1 = 1'b0, in_ready1, out_valid1, carry1;
  logic a1 = 1'b0, b1 = 1'b0, sum1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .carry(carry1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    tick();
    in_valid = 1'b0;
  endtask

  // exp is the hand-computed or golden {carry, sum}
  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic [8:0] exp,
                    input int stall, input bit busy);
    int n = 0;
    accept(x, y);
    while (!out_valid && n < 40) begin
      if (busy) begin
        check("busy_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), 32'd8);
    check("result", {23'd0, carry, sum}, {23'd0, exp});
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_result", {23'd0, carry, sum}, {23'd0, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic op1(input logic x, input logic y, input logic [1:0] exp);
    int n = 0;
    in_valid1 = 1'b1;
    a1 = x;
    b1 = y;
    tick();
    in_valid1 = 1'b0;
    while (!out_valid1 && n < 10) begin
      tick();
      n++;
    end
    check("w1_latency", 32'(n), 32'd1);
    check("w1_result", {30'd0, carry1, sum1}, {30'd0, exp});
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("w1_post_in_ready", 32'(in_ready1), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    tick();
    check("rst_in_ready_during", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    tick();
    check("rst_no_start", 32'(in_ready), 32'd1);

    op(8'hFF, 8'h01, 9'h100, 0, 1'b0);
    op(8'h5A, 8'h25, 9'h07F, 0, 1'b0);
    op(8'h80, 8'h80, 9'h100, 10, 1'b0);
    op(8'h3C, 8'hC3, 9'h0FF, 1, 1'b1);
    op(8'hA7, 8'h9B, 9'h142, 0, 1'b1);

    begin
      bit seen = 1'b0;
      accept(8'hFF, 8'hFF);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 12; i++) begin
        seen |= out_valid;
        tick();
      end
      check("abort_no_result", 32'(seen), 32'd0);
    end
    op(8'h0F, 8'h01, 9'h010, 0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = 8'($urandom);
      op(x, y, 9'(x) + 9'(y), int'($urandom_range(0, 3)), 1'b0);
    end

    op1(1'b0, 1'b0, 2'b00);
    op1(1'b0, 1'b1, 2'b01);
    op1(1'b1, 1'b0, 2'b01);
    op1(1'b1, 1'b1, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
